// File: rtl/stage2_stack_access.sv
// rtl/stage2_stack_access.sv - stack memory access stage: push writes, registered pop read, depth and error tracking
//
// Purpose:
//   Second stage of a stack pipeline. The upstream stage supplies the
//   pre-update stack pointer; this stage writes on push, reads the entry
//   below the pointer on pop, tracks occupancy and flags over/underflow.
//
// Ports:
//   CLK        - clock, rising edge
//   Reset_n    - asynchronous active-low reset
//   ReqValid   - upstream presents a push/pop request
//   ReqReady   - request accepted this cycle (low only while a pop result stalls)
//   Op         - 0 = push, 1 = pop
//   SPIn       - pre-update stack pointer; only the low log2(DEPTH) bits are used
//   PushData   - data written on push
//   PopData    - registered pop result
//   PopValid   - PopData holds an unconsumed result
//   PopReady   - downstream consumes PopData
//   Depth      - number of occupied entries (0..DEPTH)
//   Overflow   - sticky: push attempted while full
//   Underflow  - sticky: pop attempted while empty
//   ErrClear   - clears both sticky flags

module stage2_stack_access #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     Op,
    input  logic [15:0]              SPIn,
    input  logic [WIDTH-1:0]         PushData,
    output logic [WIDTH-1:0]         PopData,
    output logic                     PopValid,
    input  logic                     PopReady,
    output logic [$clog2(DEPTH):0]   Depth,
    output logic                     Overflow,
    output logic                     Underflow,
    input  logic                     ErrClear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Storage is deliberately left out of reset: Depth = 0 after reset
    // makes every entry unreachable until it has been rewritten.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;
    logic [AW:0]      r_depth;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_overflow_evt;
    logic             w_underflow_evt;
    logic [AW-1:0]    w_idx;
    logic [AW-1:0]    w_pop_idx;
    logic             w_unused_sp_hi;

    // Stall new requests only while a pop result is waiting to be taken,
    // so an unconsumed PopData is never overwritten.
    assign ReqReady = !(r_pop_valid && !PopReady);

    assign w_accept = ReqValid && ReqReady;
    assign w_push   = w_accept && !Op;
    assign w_pop    = w_accept && Op;

    assign w_full   = (r_depth == FULL_COUNT);
    assign w_empty  = (r_depth == '0);

    assign w_push_ok       = w_push && !w_full;
    assign w_pop_ok        = w_pop  && !w_empty;
    assign w_overflow_evt  = w_push && w_full;
    assign w_underflow_evt = w_pop  && w_empty;

    // The pointer arrives before the upstream update, so a pop reads the
    // entry just below it; the AW-bit subtraction gives the modulo wrap.
    assign w_idx     = SPIn[AW-1:0];
    assign w_pop_idx = w_idx - AW'(1);

    // Upper pointer bits are intentionally ignored.
    assign w_unused_sp_hi = ^SPIn[15:AW];

    // Memory write. Because only one operation is accepted per cycle and
    // the read happens on a later cycle's edge, a pop right after a push to
    // the same slot sees the new data.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[w_idx] <= PushData;
        end
    end

    // Pop result register. A new pop on the same edge as a consume keeps
    // PopValid high and replaces the data; otherwise a consume clears it.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else if (w_pop_ok) begin
            r_pop_data  <= r_mem[w_pop_idx];
            r_pop_valid <= 1'b1;
        end else if (r_pop_valid && PopReady) begin
            r_pop_valid <= 1'b0;
        end
    end

    // Occupancy counter.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_depth <= '0;
        end else if (w_push_ok) begin
            r_depth <= r_depth + 1'b1;
        end else if (w_pop_ok) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // Sticky error flags: a fresh event on the clearing edge wins.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !ErrClear) || w_overflow_evt;
            r_underflow <= (r_underflow && !ErrClear) || w_underflow_evt;
        end
    end

    assign PopData   = r_pop_data;
    assign PopValid  = r_pop_valid;
    assign Depth     = r_depth;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

endmodule

// File: tb/tb_stage2_stack_access.sv
// tb/tb_stage2_stack_access.sv - self-checking bench for stage2_stack_access
module tb_stage2_stack_access;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        ReqValid;
    logic        ReqReady;
    logic        Op;
    logic [15:0] SPIn;
    logic [WIDTH-1:0] PushData;
    logic [WIDTH-1:0] PopData;
    logic        PopValid;
    logic        PopReady;
    logic [4:0]  Depth;
    logic        Overflow;
    logic        Underflow;
    logic        ErrClear;

    always #5 CLK = ~CLK;

    stage2_stack_access #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .Op        (Op),
        .SPIn      (SPIn),
        .PushData  (PushData),
        .PopData   (PopData),
        .PopValid  (PopValid),
        .PopReady  (PopReady),
        .Depth     (Depth),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .ErrClear  (ErrClear)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: an array for storage plus plain counters/flags.
    int m_mem   [DEPTH];
    bit m_known [DEPTH];
    int m_depth;
    bit m_pv;
    int m_pd;
    bit m_pd_known;
    bit m_ovf;
    bit m_unf;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_depth    = 0;
        m_pv       = 1'b0;
        m_pd       = 0;
        m_pd_known = 1'b1;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    // Applies one clock edge worth of the stack rules to the model,
    // using the inputs as they were just before the edge.
    task automatic model_update();
        bit acc;
        bit popped;
        bit ovf_e;
        bit unf_e;
        int idx;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        acc    = ReqValid && !(m_pv && !PopReady);
        popped = 1'b0;
        ovf_e  = 1'b0;
        unf_e  = 1'b0;
        idx    = int'(SPIn) % DEPTH;
        if (acc && !Op) begin
            if (m_depth < DEPTH) begin
                m_mem[idx]   = int'(PushData);
                m_known[idx] = 1'b1;
                m_depth      = m_depth + 1;
            end else begin
                ovf_e = 1'b1;
            end
        end
        if (acc && Op) begin
            if (m_depth > 0) begin
                idx        = (idx + DEPTH - 1) % DEPTH;
                m_pd       = m_mem[idx];
                m_pd_known = m_known[idx];
                m_pv       = 1'b1;
                m_depth    = m_depth - 1;
                popped     = 1'b1;
            end else begin
                unf_e = 1'b1;
            end
        end
        if (!popped && m_pv && PopReady) m_pv = 1'b0;
        m_ovf = (m_ovf && !ErrClear) || ovf_e;
        m_unf = (m_unf && !ErrClear) || unf_e;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic set_in(input bit v, input bit op, input int sp, input int d,
                          input bit pr, input bit ec);
        ReqValid = v;
        Op       = op;
        SPIn     = 16'(sp);
        PushData = 16'(d);
        PopReady = pr;
        ErrClear = ec;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 1, 0);
        Reset_n = 1'b0;
        model_reset();
        tick();
        Reset_n = 1'b1;
    endtask

    // Single compare process, away from the active edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("req_ready", int'(ReqReady), int'(!(m_pv && !PopReady)));
            chk("pop_valid", int'(PopValid), int'(m_pv));
            chk("depth",     int'(Depth),    m_depth);
            chk("overflow",  int'(Overflow), int'(m_ovf));
            chk("underflow", int'(Underflow), int'(m_unf));
            if (m_pd_known) chk("pop_data", int'(PopData), m_pd);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 0;
            m_known[i] = 1'b0;
        end
        Reset_n = 1'b0;
        set_in(0, 0, 0, 0, 1, 0);
        model_reset();
        cmp_en = 1'b1;
        repeat (2) tick();
        Reset_n = 1'b1;
        chk("rst_depth",     int'(Depth), 0);
        chk("rst_pop_valid", int'(PopValid), 0);
        chk("rst_pop_data",  int'(PopData), 0);

        // Basic push/push/pop; the first push lands on the first edge.
        set_in(1, 0, 0, 'h1111, 0, 0); tick();
        chk("first_push_depth", int'(Depth), 1);
        set_in(1, 0, 1, 'h2222, 0, 0); tick();
        set_in(1, 1, 2, 0, 0, 0);      tick();
        chk("seq_pop_data",   int'(PopData), 'h2222);
        chk("seq_pop_valid",  int'(PopValid), 1);
        chk("seq_depth",      int'(Depth), 1);
        chk("model_pop_data", m_pd, 'h2222);
        chk("model_depth",    m_depth, 1);
        set_in(0, 0, 0, 0, 1, 0); tick();
        chk("seq_pv_clear", int'(PopValid), 0);

        // Empty pop, then clear.
        do_reset();
        set_in(1, 1, 0, 0, 1, 0); tick();
        chk("empty_underflow", int'(Underflow), 1);
        chk("empty_pv",        int'(PopValid), 0);
        chk("empty_depth",     int'(Depth), 0);
        set_in(0, 0, 0, 0, 1, 1); tick();
        chk("empty_clear", int'(Underflow), 0);

        // Fill, overflow, clear-vs-new-overflow, drain with wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 0, i, 'hA000 + i, 1, 0); tick();
        end
        chk("full_depth", int'(Depth), 16);
        chk("full_no_ovf", int'(Overflow), 0);
        set_in(1, 0, 16, 'hDEAD, 1, 0); tick();
        chk("full_ovf",   int'(Overflow), 1);
        chk("full_depth2", int'(Depth), 16);
        set_in(1, 0, 17, 'hBEEF, 1, 1); tick();
        chk("ovf_wins_clear", int'(Overflow), 1);
        chk("model_ovf", int'(m_ovf), 1);
        set_in(0, 0, 0, 0, 1, 1); tick();
        chk("ovf_cleared", int'(Overflow), 0);
        for (int sp = 16; sp >= 1; sp--) begin
            set_in(1, 1, sp, 0, 1, 0); tick();
            chk("drain_data", int'(PopData), 'hA000 + ((sp - 1) % 16));
            chk("drain_pv",   int'(PopValid), 1);
        end
        chk("drain_depth", int'(Depth), 0);
        set_in(0, 0, 0, 0, 1, 0); tick();

        // Back-pressure.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, i, 'hB000 + i, 1, 0); tick();
        end
        set_in(1, 1, 3, 0, 0, 0); tick();
        chk("bp_first", int'(PopData), 'hB002);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 2, 0, 0, 0);
            #1 chk("bp_ready_low", int'(ReqReady), 0);
            tick();
            chk("bp_data_stable", int'(PopData), 'hB002);
            chk("bp_pv_stable",   int'(PopValid), 1);
            chk("bp_depth",       int'(Depth), 2);
        end
        set_in(1, 1, 2, 0, 1, 0); tick();
        chk("bp_new_data", int'(PopData), 'hB001);
        chk("bp_pv_held",  int'(PopValid), 1);
        set_in(1, 0, 1, 'hC0DE, 1, 0);
        #1 chk("push_pending_ready", int'(ReqReady), 1);
        tick();
        chk("push_pending_depth", int'(Depth), 2);
        set_in(1, 1, 2, 0, 1, 0); tick();
        chk("push_pending_read", int'(PopData), 'hC0DE);
        set_in(0, 0, 0, 0, 1, 0); tick();

        // Asynchronous reset mid-operation.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, i, 'hD000 + i, 1, 0); tick();
        end
        set_in(1, 1, 6, 0, 0, 0); tick();
        chk("pre_rst_depth", int'(Depth), 5);
        chk("pre_rst_pv",    int'(PopValid), 1);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pv",    int'(PopValid), 0);
        chk("async_rst_depth", int'(Depth), 0);
        set_in(0, 0, 0, 0, 1, 0);
        tick();
        Reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int sp;
            if ($urandom_range(0, 1) == 0)
                sp = m_depth + 16 * int'($urandom_range(0, 4095));
            else
                sp = int'($urandom_range(0, 65535));
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, sp,
                   int'($urandom_range(0, 65535)), $urandom_range(0, 9) < 6,
                   $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        set_in(0, 0, 0, 0, 1, 0);
        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage2_stack_access.md
STAGE2_STACK_ACCESS -- requirements
Module: stage2_stack_access

Interface
REQ-001 Parameter DEPTH, default 16: number of stack entries; the index is SPIn[log2(DEPTH)-1:0].
REQ-002 Parameter WIDTH, default 16: data width of a stack entry.
REQ-003 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 ReqValid  input  1  the upstream stack-pointer stage presents a push/pop request.
REQ-006 ReqReady  output  1  this block accepts the request this cycle.
REQ-007 Op  input  1  0 = push (the upstream stage increments SP), 1 = pop (the upstream stage decrements SP).
REQ-008 SPIn  input  16  pre-update stack pointer from the upstream incrementer stage.
REQ-009 PushData  input  WIDTH  data written on push.
REQ-010 PopData  output  WIDTH  registered pop result.
REQ-011 PopValid  output  1  PopData holds an unconsumed pop result.
REQ-012 PopReady  input  1  the downstream stage consumes PopData.
REQ-013 Depth  output  log2(DEPTH)+1  current number of occupied entries.
REQ-014 Overflow  output  1  sticky flag: a push was attempted while full.
REQ-015 Underflow  output  1  sticky flag: a pop was attempted while empty.
REQ-016 ErrClear  input  1  clears Overflow and Underflow.

Function
REQ-017 Request acceptance SHALL be defined as accept = ReqValid && ReqReady.
REQ-018 ReqReady SHALL equal !(PopValid && !PopReady), combinationally.
REQ-019 A push accepted with Depth < DEPTH SHALL, on the edge:
- write PushData to mem[SPIn index];
- increment Depth.
REQ-020 A push accepted with Depth == DEPTH SHALL:
- perform no write;
- leave Depth unchanged;
- set Overflow.
REQ-021 A pop accepted with Depth > 0 SHALL, on the edge:
- load PopData with mem[(SPIn index - 1) mod DEPTH];
- set PopValid;
- decrement Depth.
REQ-022 A pop accepted with Depth == 0 SHALL:
- leave PopData, PopValid and Depth unchanged;
- set Underflow.
REQ-023 Pop latency SHALL be one cycle: data from a pop accepted in cycle N is visible after edge N.
REQ-024 A pop in cycle N+1 SHALL return data pushed in cycle N to the same index (no stale read).
REQ-025 PopValid SHALL clear on an edge where PopValid && PopReady, unless a new pop is accepted on that same edge, in which case PopValid stays 1 and PopData updates.
REQ-026 PopData and PopValid SHALL hold stable while PopValid && !PopReady.
REQ-027 Index arithmetic SHALL wrap modulo DEPTH; SPIn bits above the index are ignored.
REQ-028 ErrClear SHALL clear both sticky flags on the edge; a new overflow or underflow on the same edge SHALL win, leaving its flag set.
REQ-029 Pushes SHALL be accepted while a pop result is pending, provided ReqReady is 1.
REQ-030 When ReqValid is 0, the block SHALL change no state except PopValid clearing per REQ-025.

Reset
REQ-031 While Reset_n is 0, asynchronously:
- PopData = 0;
- PopValid = 0;
- Depth = 0;
- Overflow = 0;
- Underflow = 0.
REQ-032 Stack memory contents SHALL NOT be reset; they are unreadable until rewritten because Depth = 0.
REQ-033 Reset asserted mid-operation SHALL discard any pending pop result and any in-flight request.
REQ-034 The first request SHALL be accepted on the first rising edge after Reset_n deasserts.

Verification
REQ-035 Push/pop sequence: push 0x1111 at SP 0, push 0x2222 at SP 1, pop at SP 2 -> PopData 0x2222, PopValid 1 one cycle later, Depth 1.
REQ-036 Full: 16 pushes at SP 0..15, then a 17th push -> Depth 16, Overflow 1, mem[0] unchanged; a following pop at SP 16 (index 0) -> data from SP 15.
REQ-037 Empty: pop after reset -> Underflow 1, PopValid 0, Depth 0; ErrClear the next cycle -> Underflow 0.
REQ-038 Back-pressure: pop with PopReady 0 for 3 cycles -> ReqReady 0 and PopData stable throughout; PopReady 1 with a concurrent pop -> new PopData, PopValid stays 1.
REQ-039 Simultaneous events: ErrClear in the same cycle as a full push -> Overflow remains 1.
REQ-040 Reset mid-operation: assert Reset_n=0 with PopValid 1 and Depth 5 -> PopValid 0 and Depth 0 immediately, without waiting for a clock edge.
